exc_collector: RTL and testbench

//  Exception/interrupt collection stage between the MEM pipeline stage and the CP0 register file.

---
 rtl/exc_collector_if.sv | 43 ++++
 rtl/exc_collector.sv | 144 ++++++++++++++
 tb/tb_exc_collector.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_collector_if.sv
// MEM-stage exception flags, CP0 state and the collector's commit/flush/redirect outputs.
interface exc_collector_if;
  logic        mem_valid;
  logic        mem_stall;
  logic [31:0] mem_pc;
  logic        mem_in_ds;
  logic        mem_ri;
  logic        mem_sys;
  logic        mem_brk;
  logic        mem_ov;
  logic        mem_eret;
  logic        mem_adel_d;
  logic        mem_ades_d;
  logic [31:0] mem_badaddr;
  logic [5:0]  int_;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;

  logic [5:0]  int_sync_o;
  logic [4:0]  exc_type_o;
  logic [31:0] exc_pc_o;
  logic        exc_in_ds_o;
  logic [31:0] exc_badaddr_o;
  logic        exc_we_mem_o;
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  modport master (
    output mem_valid, mem_stall, mem_pc, mem_in_ds, mem_ri, mem_sys, mem_brk, mem_ov,
           mem_eret, mem_adel_d, mem_ades_d, mem_badaddr, int_, cp0_status, cp0_cause, cp0_epc,
    input  int_sync_o, exc_type_o, exc_pc_o, exc_in_ds_o, exc_badaddr_o, exc_we_mem_o,
           flush_o, redirect_o, redirect_pc_o
  );

  modport slave (
    input  mem_valid, mem_stall, mem_pc, mem_in_ds, mem_ri, mem_sys, mem_brk, mem_ov,
           mem_eret, mem_adel_d, mem_ades_d, mem_badaddr, int_, cp0_status, cp0_cause, cp0_epc,
    output int_sync_o, exc_type_o, exc_pc_o, exc_in_ds_o, exc_badaddr_o, exc_we_mem_o,
           flush_o, redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/exc_collector.sv
// Picks the highest-priority MEM-stage exception or interrupt, commits it to CP0 for one cycle,
// then holds flush for FLUSH_CYCLES cycles and a one-cycle clear before accepting again.
module exc_collector #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  exc_collector_if.slave bus
);
  localparam int unsigned CW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  localparam logic [4:0] CODE_NONE = 5'b11111;
  localparam logic [4:0] CODE_INT  = 5'b00000;
  localparam logic [4:0] CODE_SINT = 5'b10111;
  localparam logic [4:0] CODE_ADEL = 5'b00001;
  localparam logic [4:0] CODE_RI   = 5'b10101;
  localparam logic [4:0] CODE_SYS  = 5'b00011;
  localparam logic [4:0] CODE_BRK  = 5'b00100;
  localparam logic [4:0] CODE_OV   = 5'b00010;
  localparam logic [4:0] CODE_ERET = 5'b00101;

  typedef enum logic [1:0] {IDLE, COMMIT, FLUSH, CLEAR} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    int_meta;

  logic          int_pend;
  logic          hw_int;
  logic [4:0]    cand_code;
  logic [31:0]   cand_bad;
  logic          cand_we;
  logic          cand_eret;
  logic          take;

  logic          unused_ok;
  assign unused_ok = ^{bus.cp0_status[31:16], bus.cp0_status[7:2],
                       bus.cp0_cause[31:10], bus.cp0_cause[7:0]};

  // Soft IP sits below the six hardware lines in the IM[15:8] mask.
  assign int_pend = bus.cp0_status[0] & ~bus.cp0_status[1] &
                    (|({bus.int_sync_o, bus.cp0_cause[9:8]} & bus.cp0_status[15:8]));
  assign hw_int   = |(bus.int_sync_o & bus.cp0_status[15:10]);

  always_comb begin
    cand_code = CODE_NONE;
    cand_bad  = 32'h0;
    cand_we   = 1'b0;
    cand_eret = 1'b0;
    if (int_pend) begin
      cand_code = hw_int ? CODE_INT : CODE_SINT;
    end else if (|bus.mem_pc[1:0]) begin
      cand_code = CODE_ADEL;
      cand_bad  = bus.mem_pc;
    end else if (bus.mem_ri) begin
      cand_code = CODE_RI;
    end else if (bus.mem_sys) begin
      cand_code = CODE_SYS;
    end else if (bus.mem_brk) begin
      cand_code = CODE_BRK;
    end else if (bus.mem_ov) begin
      cand_code = CODE_OV;
    end else if (bus.mem_adel_d) begin
      cand_code = CODE_ADEL;
      cand_bad  = bus.mem_badaddr;
    end else if (bus.mem_ades_d) begin
      cand_code = CODE_ADEL;
      cand_bad  = bus.mem_badaddr;
      cand_we   = 1'b1;
    end else if (bus.mem_eret) begin
      cand_code = CODE_ERET;
      cand_eret = 1'b1;
    end
  end

  assign take = bus.mem_valid & ~bus.mem_stall & (cand_code != CODE_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      int_meta          <= 6'h0;
      bus.int_sync_o    <= 6'h0;
      bus.exc_type_o    <= CODE_NONE;
      bus.exc_pc_o      <= 32'h0;
      bus.exc_in_ds_o   <= 1'b0;
      bus.exc_badaddr_o <= 32'h0;
      bus.exc_we_mem_o  <= 1'b0;
      bus.flush_o       <= 1'b0;
      bus.redirect_o    <= 1'b0;
      bus.redirect_pc_o <= 32'h0;
    end else begin
      int_meta       <= bus.int_;
      bus.int_sync_o <= int_meta;
      case (state)
        IDLE: begin
          if (take) begin
            bus.exc_type_o    <= cand_code;
            bus.exc_pc_o      <= bus.mem_pc;
            bus.exc_in_ds_o   <= bus.mem_in_ds;
            bus.exc_badaddr_o <= cand_bad;
            bus.exc_we_mem_o  <= cand_we;
            bus.flush_o       <= 1'b1;
            bus.redirect_o    <= 1'b1;
            bus.redirect_pc_o <= cand_eret ? bus.cp0_epc : EXC_VECTOR;
            state             <= COMMIT;
          end
        end
        COMMIT: begin
          // CP0 must see the event for exactly this one cycle.
          bus.exc_type_o    <= CODE_NONE;
          bus.exc_pc_o      <= 32'h0;
          bus.exc_in_ds_o   <= 1'b0;
          bus.exc_badaddr_o <= 32'h0;
          bus.exc_we_mem_o  <= 1'b0;
          bus.redirect_o    <= 1'b0;
          bus.redirect_pc_o <= 32'h0;
          cnt               <= CNT_LOAD;
          if (CNT_LOAD == '0) begin
            bus.flush_o <= 1'b0;
            state       <= CLEAR;
          end else begin
            bus.flush_o <= 1'b1;
            state       <= FLUSH;
          end
        end
        FLUSH: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            bus.flush_o <= 1'b0;
            state       <= CLEAR;
          end
        end
        CLEAR: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exc_collector.sv
// Scenario bench for exc_collector: expected commits are queued at stimulus time and
// matched against commits captured from the DUT outputs.
module tb_exc_collector;
  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam logic [31:0] EPC = 32'h80001234;

  typedef struct packed {
    logic [4:0]  typ;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic        we;
    logic [31:0] rpc;
    logic        flush;
    logic        redir;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  ev_t  o;
  ev_t  e;

  always #5 clk = ~clk;

  exc_collector_if bus();

  exc_collector #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic idle_inputs();
    bus.mem_valid   = 1'b0;
    bus.mem_stall   = 1'b0;
    bus.mem_in_ds   = 1'b0;
    bus.mem_ri      = 1'b0;
    bus.mem_sys     = 1'b0;
    bus.mem_brk     = 1'b0;
    bus.mem_ov      = 1'b0;
    bus.mem_eret    = 1'b0;
    bus.mem_adel_d  = 1'b0;
    bus.mem_ades_d  = 1'b0;
    bus.mem_badaddr = 32'h0;
  endtask

  function automatic ev_t mk(logic [4:0] t, logic [31:0] pc, logic ds, logic [31:0] bad,
                             logic we, logic [31:0] rpc);
    mk = '{typ: t, pc: pc, ds: ds, bad: bad, we: we, rpc: rpc, flush: 1'b1, redir: 1'b1};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.mem_pc = 32'h0;
    bus.int_ = 6'h0;
    bus.cp0_status = 32'h0;
    bus.cp0_cause = 32'h0;
    bus.cp0_epc = EPC;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.exc_type_o !== 5'b11111) begin n_err++; $display("FAIL reset_type got %b want 11111", bus.exc_type_o); end
    n_cmp++;
    if ({bus.flush_o, bus.redirect_o} !== 2'b00) begin n_err++; $display("FAIL reset_flush_redir got %b want 00", {bus.flush_o, bus.redirect_o}); end
    n_cmp++;
    if (bus.int_sync_o !== 6'h0) begin n_err++; $display("FAIL reset_int_sync got %h want 0", bus.int_sync_o); end
    n_cmp++;
    if ({bus.exc_pc_o, bus.exc_badaddr_o, bus.redirect_pc_o} !== 96'h0) begin n_err++; $display("FAIL reset_buses got %h %h %h want 0", bus.exc_pc_o, bus.exc_badaddr_o, bus.redirect_pc_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Instruction held valid through COMMIT, FLUSH and CLEAR: only the first cycle may commit.
  task automatic test_sys();
    exp_q.push_back(mk(5'b00011, 32'hBFC00100, 1'b0, 32'h0, 1'b0, VEC));
    bus.mem_valid = 1'b1; bus.mem_sys = 1'b1; bus.mem_pc = 32'hBFC00100;
    @(negedge clk);
    n_cmp++;
    if (obs_q.size() == 0) begin n_err++; $display("FAIL sys_commit got none want 1 event"); end
    else begin o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin n_err++; $display("FAIL sys_commit got %h want %h", o, e); end end
    @(negedge clk);
    n_cmp++;
    if ({bus.flush_o, bus.exc_type_o, bus.redirect_o} !== {1'b1, 5'b11111, 1'b0}) begin
      n_err++; $display("FAIL sys_flush got %b want 1111110", {bus.flush_o, bus.exc_type_o, bus.redirect_o}); end
    @(negedge clk);
    n_cmp++;
    if (bus.flush_o !== 1'b0) begin n_err++; $display("FAIL sys_clear got flush=%b want 0", bus.flush_o); end
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL sys_single got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_multi_flag();
    exp_q.push_back(mk(5'b10101, 32'h80000010, 1'b1, 32'h0, 1'b0, VEC));
    bus.mem_valid = 1'b1; bus.mem_ri = 1'b1; bus.mem_ov = 1'b1; bus.mem_ades_d = 1'b1;
    bus.mem_in_ds = 1'b1; bus.mem_badaddr = 32'h12345678; bus.mem_pc = 32'h80000010;
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (obs_q.size() == 0) begin n_err++; $display("FAIL multi_commit got none want 1 event"); end
    else begin o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin n_err++; $display("FAIL multi_commit got %h want %h", o, e); end end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL multi_single got %0d extra want 0", obs_q.size()); obs_q.delete(); end
  endtask

  // One event per table row: ri, brk, ov, data AdEL, data AdES, eret.
  task automatic test_single_flags();
    for (int k = 0; k < 6; k++) begin
      logic [31:0] pc;
      pc = 32'h80000400 + 32'(k * 16);
      bus.mem_valid = 1'b1; bus.mem_pc = pc; bus.mem_badaddr = 32'hA0000000 + 32'(k);
      case (k)
        0: begin bus.mem_ri = 1'b1;     exp_q.push_back(mk(5'b10101, pc, 1'b0, 32'h0, 1'b0, VEC)); end
        1: begin bus.mem_brk = 1'b1;    exp_q.push_back(mk(5'b00100, pc, 1'b0, 32'h0, 1'b0, VEC)); end
        2: begin bus.mem_ov = 1'b1;     exp_q.push_back(mk(5'b00010, pc, 1'b0, 32'h0, 1'b0, VEC)); end
        3: begin bus.mem_adel_d = 1'b1; exp_q.push_back(mk(5'b00001, pc, 1'b0, 32'hA0000003, 1'b0, VEC)); end
        4: begin bus.mem_ades_d = 1'b1; bus.mem_eret = 1'b1; exp_q.push_back(mk(5'b00001, pc, 1'b0, 32'hA0000004, 1'b1, VEC)); end
        default: begin bus.mem_eret = 1'b1; exp_q.push_back(mk(5'b00101, pc, 1'b0, 32'h0, 1'b0, EPC)); end
      endcase
      @(negedge clk);
      idle_inputs();
      n_cmp++;
      if (obs_q.size() == 0) begin n_err++; $display("FAIL flag%0d_commit got none want 1 event", k); end
      else begin o = obs_q.pop_front(); e = exp_q.pop_front();
        if (o !== e) begin n_err++; $display("FAIL flag%0d_commit got %h want %h", k, o, e); end end
      repeat (3) @(negedge clk);
    end
    exp_q.delete();
  endtask

  task automatic test_interrupt();
    bus.cp0_status = 32'h00000401;
    bus.int_ = 6'b000001;
    @(negedge clk);
    n_cmp++;
    if (bus.int_sync_o !== 6'h0) begin n_err++; $display("FAIL int_sync_1clk got %b want 000000", bus.int_sync_o); end
    @(negedge clk);
    n_cmp++;
    if (bus.int_sync_o !== 6'b000001) begin n_err++; $display("FAIL int_sync_2clk got %b want 000001", bus.int_sync_o); end
    exp_q.push_back(mk(5'b00000, 32'h80000100, 1'b0, 32'h0, 1'b0, VEC));
    bus.mem_valid = 1'b1; bus.mem_pc = 32'h80000100;
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (obs_q.size() == 0) begin n_err++; $display("FAIL hw_int got none want 1 event"); end
    else begin o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin n_err++; $display("FAIL hw_int got %h want %h", o, e); end end
    repeat (4) @(negedge clk);
    bus.cp0_status = 32'h00000403;
    bus.mem_valid = 1'b1;
    repeat (2) @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL int_exl got %0d events want 0", obs_q.size()); obs_q.delete(); end
    bus.int_ = 6'h0;
    bus.cp0_status = 32'h00000101;
    bus.cp0_cause = 32'h00000100;
    repeat (3) @(negedge clk);
    exp_q.push_back(mk(5'b10111, 32'h80000104, 1'b0, 32'h0, 1'b0, VEC));
    bus.mem_valid = 1'b1; bus.mem_pc = 32'h80000104;
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (obs_q.size() == 0) begin n_err++; $display("FAIL soft_int got none want 1 event"); end
    else begin o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin n_err++; $display("FAIL soft_int got %h want %h", o, e); end end
    bus.cp0_status = 32'h0;
    bus.cp0_cause = 32'h0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_eret_stall();
    exp_q.push_back(mk(5'b00101, 32'h80000200, 1'b0, 32'h0, 1'b0, EPC));
    bus.mem_valid = 1'b1; bus.mem_eret = 1'b1; bus.mem_stall = 1'b1; bus.mem_pc = 32'h80000200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_q.size() != 0) begin n_err++; $display("FAIL eret_stall%0d got event want none", i); obs_q.delete(); end
    end
    bus.mem_stall = 1'b0;
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (obs_q.size() == 0) begin n_err++; $display("FAIL eret_commit got none want 1 event"); end
    else begin o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin n_err++; $display("FAIL eret_commit got %h want %h", o, e); end end
    repeat (4) @(negedge clk);
    exp_q.delete();
  endtask

  // Fetch error beats RI; reset during FLUSH must leave the FSM ready in IDLE.
  task automatic test_fetch_rst();
    exp_q.push_back(mk(5'b00001, 32'h80000002, 1'b0, 32'h80000002, 1'b0, VEC));
    bus.mem_valid = 1'b1; bus.mem_ri = 1'b1; bus.mem_pc = 32'h80000002; bus.mem_badaddr = 32'hDEAD0000;
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (obs_q.size() == 0) begin n_err++; $display("FAIL fetch_adel got none want 1 event"); end
    else begin o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin n_err++; $display("FAIL fetch_adel got %h want %h", o, e); end end
    @(negedge clk);
    n_cmp++;
    if (bus.flush_o !== 1'b1) begin n_err++; $display("FAIL fetch_flush got %b want 1", bus.flush_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({bus.flush_o, bus.exc_type_o, bus.redirect_o} !== {1'b0, 5'b11111, 1'b0}) begin
      n_err++; $display("FAIL rst_mid got %b want 0111110", {bus.flush_o, bus.exc_type_o, bus.redirect_o}); end
    exp_q.push_back(mk(5'b00011, 32'h80000300, 1'b0, 32'h0, 1'b0, VEC));
    bus.mem_valid = 1'b1; bus.mem_sys = 1'b1; bus.mem_pc = 32'h80000300;
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (obs_q.size() == 0) begin n_err++; $display("FAIL post_rst_idle got none want 1 event"); end
    else begin o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) begin n_err++; $display("FAIL post_rst_idle got %h want %h", o, e); end end
    repeat (4) @(negedge clk);
    exp_q.delete();
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        #1;
        if (bus.exc_type_o !== 5'b11111)
          obs_q.push_back('{typ: bus.exc_type_o, pc: bus.exc_pc_o, ds: bus.exc_in_ds_o,
                            bad: bus.exc_badaddr_o, we: bus.exc_we_mem_o, rpc: bus.redirect_pc_o,
                            flush: bus.flush_o, redir: bus.redirect_o});
      end
    join_none
    test_reset();
    test_sys();
    test_multi_flag();
    test_single_flags();
    test_interrupt();
    test_eret_stall();
    test_fetch_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
